// File: rtl/bus_switch_sequencer.sv
// bus_switch_sequencer: arbitrates transfer requests and sequences bus switch controls with direction turnaround (optional BUS_SWITCH_SEQ_RR_EN)
module bus_switch_sequencer #(
   parameter int HOLD_CYCLES = 1,
   parameter int TURN_CYCLES = 1
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       req0,
   input  logic [1:0] src0,
   input  logic [1:0] dst0,
   input  logic       mask0,
   input  logic       req1,
   input  logic [1:0] src1,
   input  logic [1:0] dst1,
   input  logic       mask1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done,
   output logic       err,
   output logic       busy,
   output logic       ctl_sw_1u,
   output logic       ctl_sw_1d,
   output logic       ctl_sw_2u,
   output logic       ctl_sw_2d,
   output logic       ctl_sw_mask543_en
);
   typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;
   typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;
   localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] TURN_M1 = 4'(TURN_CYCLES - 1);
   state_t     state_q, state_d;
   dir_t       ld1_q, ld1_d, ld2_q, ld2_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] route_q, route_d;
   logic       mask_q, mask_d;
   logic [9:0] out_q, out_d;
   logic [1:0] gnt_d;
   logic       err_d, drive_d, sel1, legal, conflict, msk;
   logic [1:0] src, dst;
   logic [3:0] rt;
`ifdef BUS_SWITCH_SEQ_RR_EN
   logic       rr_q, rr_d;
   assign sel1 = req1 & (~req0 | rr_q);
`else
   assign sel1 = ~req0;
`endif
   assign src      = sel1 ? src1 : src0;
   assign dst      = sel1 ? dst1 : dst0;
   assign msk      = sel1 ? mask1 : mask0;
   assign legal    = (src != dst) && (src != 2'd3) && (dst != 2'd3);
   assign rt       = {src == 2'd0, dst == 2'd0, dst == 2'd2, src == 2'd2};
   assign conflict = (rt[3] && ld1_q == DOWN) || (rt[2] && ld1_q == UP) ||
                     (rt[1] && ld2_q == DOWN) || (rt[0] && ld2_q == UP);
   assign {gnt0, gnt1, done, err, busy, ctl_sw_1u, ctl_sw_1d, ctl_sw_2u, ctl_sw_2d, ctl_sw_mask543_en} = out_q;
   // next-state, arbitration and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      route_d = route_q;
      mask_d  = mask_q;
      ld1_d   = ld1_q;
      ld2_d   = ld2_q;
      gnt_d   = 2'b00;
      err_d   = 1'b0;
`ifdef BUS_SWITCH_SEQ_RR_EN
      rr_d    = rr_q;
`endif
      case (state_q)
         IDLE: if (req0 || req1) begin
            gnt_d = sel1 ? 2'b01 : 2'b10;
            err_d = ~legal;
`ifdef BUS_SWITCH_SEQ_RR_EN
            rr_d  = ~sel1;
`endif
            if (legal) begin
               route_d = rt;
               mask_d  = msk & rt[2];
               state_d = conflict ? TURN : DRIVE;
               cnt_d   = conflict ? TURN_M1 : HOLD_M1;
            end
         end
         TURN: begin
            state_d = (cnt_q == 4'd0) ? DRIVE : TURN;
            cnt_d   = (cnt_q == 4'd0) ? HOLD_M1 : cnt_q - 4'd1;
         end
         DRIVE: if (cnt_q == 4'd0) begin
            state_d = IDLE;
            ld1_d   = route_q[3] ? UP : route_q[2] ? DOWN : ld1_q;
            ld2_d   = route_q[1] ? UP : route_q[0] ? DOWN : ld2_q;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      drive_d = (state_d == DRIVE);
      out_d   = {gnt_d, drive_d && cnt_d == 4'd0, err_d, state_d != IDLE,
                 drive_d ? route_d : 4'b0000, drive_d & mask_d};
   end
   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         route_q <= '0;
         mask_q  <= 1'b0;
         ld1_q   <= NONE;
         ld2_q   <= NONE;
         out_q   <= '0;
`ifdef BUS_SWITCH_SEQ_RR_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         route_q <= route_d;
         mask_q  <= mask_d;
         ld1_q   <= ld1_d;
         ld2_q   <= ld2_d;
         out_q   <= out_d;
`ifdef BUS_SWITCH_SEQ_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end
endmodule
